cond_unit: RTL and testbench

Condition-evaluation and flag-register stage sitting directly downstream of the ALU in the ARM-32 datapath. It holds the architectural NZCV flags, evaluates each instruction's 4-bit condition field against them, and gates the decoder's write enables. It also updates NZ and/or CV from the ALU's `ALUFlags` when the instruction executes. Gated controls leave through a one-entry pipeline register with stall/flush control, and a saturating counter tracks squashed instructions.

---
 rtl/cond_unit.sv | 122 ++++++++++++
 tb/tb_cond_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Condition-evaluation and NZCV flag stage behind the ALU: decodes the condition
// field, gates write enables, and registers the gated controls with stall/flush.
module cond_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             stall,
    input  logic             flush,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             out_valid,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [CNT_W-1:0] skip_count
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] skipCount_q, skipCount_d;
    logic             outValid_q, outValid_d;
    logic             pcSrc_q, pcSrc_d;
    logic             regWrite_q, regWrite_d;
    logic             memWrite_q, memWrite_d;

    logic flagN, flagZ, flagC, flagV;
    logic condEx;
    logic accept;

    assign flagN = flags_q[3];
    assign flagZ = flags_q[2];
    assign flagC = flags_q[1];
    assign flagV = flags_q[0];

    // Decode always looks at the registered flags; ALUFlags is never forwarded here.
    always_comb begin
        condEx = 1'b0;
        case (Cond)
            4'b0000: condEx = flagZ;
            4'b0001: condEx = ~flagZ;
            4'b0010: condEx = flagC;
            4'b0011: condEx = ~flagC;
            4'b0100: condEx = flagN;
            4'b0101: condEx = ~flagN;
            4'b0110: condEx = flagV;
            4'b0111: condEx = ~flagV;
            4'b1000: condEx = flagC & ~flagZ;
            4'b1001: condEx = ~flagC | flagZ;
            4'b1010: condEx = (flagN == flagV);
            4'b1011: condEx = (flagN != flagV);
            4'b1100: condEx = ~flagZ & (flagN == flagV);
            4'b1101: condEx = flagZ | (flagN != flagV);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    assign accept = in_valid & ~stall & ~flush;

    always_comb begin
        flags_d     = flags_q;
        skipCount_d = skipCount_q;
        outValid_d  = outValid_q;
        pcSrc_d     = pcSrc_q;
        regWrite_d  = regWrite_q;
        memWrite_d  = memWrite_q;

        if (flush || (!stall && !in_valid)) begin
            outValid_d = 1'b0;
            pcSrc_d    = 1'b0;
            regWrite_d = 1'b0;
            memWrite_d = 1'b0;
        end else if (accept) begin
            outValid_d = 1'b1;
            pcSrc_d    = PCS & condEx;
            regWrite_d = RegW & ~NoWrite & condEx;
            memWrite_d = MemW & condEx;
            if (condEx) begin
                if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
                if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
            end else if (skipCount_q != {CNT_W{1'b1}}) begin
                // Saturate rather than wrap so a long squashed run stays visible.
                skipCount_d = skipCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'b0000;
            skipCount_q <= '0;
            outValid_q  <= 1'b0;
            pcSrc_q     <= 1'b0;
            regWrite_q  <= 1'b0;
            memWrite_q  <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            skipCount_q <= skipCount_d;
            outValid_q  <= outValid_d;
            pcSrc_q     <= pcSrc_d;
            regWrite_q  <= regWrite_d;
            memWrite_q  <= memWrite_d;
        end
    end

    assign CondEx     = condEx;
    assign Flags      = flags_q;
    assign out_valid  = outValid_q;
    assign PCSrc      = pcSrc_q;
    assign RegWrite   = regWrite_q;
    assign MemWrite   = memWrite_q;
    assign skip_count = skipCount_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit: flag updates, condition decode,
// stall/flush behaviour, reset and skip-counter saturation.
module tb_cond_unit;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, stall, flush;
    logic       CondEx;
    logic [3:0] Flags;
    logic       out_valid, PCSrc, RegWrite, MemWrite;
    logic [7:0] skip_count;

    int checks   = 0;
    int failures = 0;
    int skipExp  = 0;

    cond_unit #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .stall      (stall),
        .flush      (flush),
        .CondEx     (CondEx),
        .Flags      (Flags),
        .out_valid  (out_valid),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .skip_count (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [3:0] af,
                                 input logic [1:0] fw, input logic pcs, input logic regw,
                                 input logic memw, input logic nw, input logic st, input logic fl);
        in_valid = v;
        Cond     = c;
        ALUFlags = af;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;
        NoWrite  = nw;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string tag, input logic ov, input logic pc,
                             input logic rw, input logic mw, input logic [3:0] fl);
        checkOutput({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        checkOutput({tag, ".PCSrc"},     {31'd0, PCSrc},     {31'd0, pc});
        checkOutput({tag, ".RegWrite"},  {31'd0, RegWrite},  {31'd0, rw});
        checkOutput({tag, ".MemWrite"},  {31'd0, MemWrite},  {31'd0, mw});
        checkOutput({tag, ".Flags"},     {28'd0, Flags},     {28'd0, fl});
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Reset state and condition decode on cleared flags
        checkRegs("reset", 0, 0, 0, 0, 4'b0000);
        checkOutput("reset.skip", {24'd0, skip_count}, 32'd0);
        applyStimulus(0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("reset.NE", {31'd0, CondEx}, 32'd1);
        applyStimulus(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("reset.EQ", {31'd0, CondEx}, 32'd0);
        applyStimulus(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("reset.AL", {31'd0, CondEx}, 32'd1);

        // Compare then branch
        applyStimulus(1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1, 0, 0);
        tick();
        checkRegs("cmp", 1, 0, 0, 0, 4'b0110);
        applyStimulus(1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0);
        checkOutput("beq.CondEx", {31'd0, CondEx}, 32'd1);
        tick();
        checkRegs("beq", 1, 1, 0, 0, 4'b0110);

        // Bubble
        applyStimulus(0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0);
        tick();
        checkRegs("bubble", 0, 0, 0, 0, 4'b0110);

        // Partial flag writes
        applyStimulus(1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pf.load", {28'd0, Flags}, {28'd0, 4'b1001});
        applyStimulus(1, 4'b1110, 4'b0110, 2'b10, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pf.nz", {28'd0, Flags}, {28'd0, 4'b0101});
        applyStimulus(1, 4'b1110, 4'b1010, 2'b01, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("pf.cv", {28'd0, Flags}, {28'd0, 4'b0110});

        // Signed / unsigned conditions
        applyStimulus(1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v0.GE", {31'd0, CondEx}, 32'd0);
        applyStimulus(0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v0.LT", {31'd0, CondEx}, 32'd1);
        applyStimulus(0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v0.GT", {31'd0, CondEx}, 32'd0);
        applyStimulus(0, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v0.LE", {31'd0, CondEx}, 32'd1);
        applyStimulus(1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v1.GE", {31'd0, CondEx}, 32'd1);
        applyStimulus(0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("n1v1.GT", {31'd0, CondEx}, 32'd1);
        applyStimulus(1, 4'b1110, 4'b0010, 2'b11, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("c1z0.HI", {31'd0, CondEx}, 32'd1);
        applyStimulus(0, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("c1z0.LS", {31'd0, CondEx}, 32'd0);
        applyStimulus(1, 4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("z1c1.LS", {31'd0, CondEx}, 32'd1);
        applyStimulus(0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        checkOutput("z1c1.HI", {31'd0, CondEx}, 32'd0);

        // Failing condition: no flag change, controls gated off, skip increments
        applyStimulus(1, 4'b0001, 4'b1001, 2'b11, 1, 1, 1, 0, 0, 0);
        tick();
        skipExp = 1;
        checkRegs("ne.fail", 1, 0, 0, 0, 4'b0110);
        checkOutput("ne.skip", {24'd0, skip_count}, skipExp);

        // Passing store+write, then stall for three cycles
        applyStimulus(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 1, 0, 0, 0);
        tick();
        checkRegs("st.load", 1, 0, 1, 1, 4'b0110);
        applyStimulus(1, 4'b1110, 4'b1111, 2'b11, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkRegs($sformatf("stall%0d", i), 1, 0, 1, 1, 4'b0110);
        end
        applyStimulus(1, 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 0);
        tick();
        checkOutput("stall.skip", {24'd0, skip_count}, skipExp);

        // Flush beats stall and valid
        applyStimulus(1, 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1);
        tick();
        checkRegs("flush", 0, 0, 0, 0, 4'b0110);
        checkOutput("flush.skip", {24'd0, skip_count}, skipExp);

        // Skip counter saturation with NV instructions
        applyStimulus(1, 4'b1111, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            tick();
            if (skipExp < 255) skipExp++;
            checkOutput("nv.RegWrite", {31'd0, RegWrite}, 32'd0);
            checkOutput("nv.skip", {24'd0, skip_count}, skipExp);
        end
        checkOutput("sat.skip", {24'd0, skip_count}, 32'd255);
        checkOutput("sat.Flags", {28'd0, Flags}, {28'd0, 4'b0110});

        // Asynchronous reset in the middle of an instruction
        applyStimulus(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        checkRegs("areset", 0, 0, 0, 0, 4'b0000);
        checkOutput("areset.skip", {24'd0, skip_count}, 32'd0);
        tick();
        applyStimulus(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b1;
        tick();
        checkRegs("postreset", 0, 0, 0, 0, 4'b0000);
        checkOutput("postreset.skip", {24'd0, skip_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL timeout: observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
